// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : card_pkg
//  Purpose  : Shared types and constants for the card shoe and its helpers.
//             card_t holds a rank 1..13 (A=1, J=11, Q=12, K=13).
//             next_rank() steps a rank with the 13 -> 1 wrap.
//  Revision : 1.0  initial release
// ============================================================================
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t RANK_MIN = 4'd1;
    localparam card_t RANK_MAX = 4'd13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMPTY  = 2'd2
    } shoe_state_t;

    // Any value outside 1..12 (including the illegal 0 and 14..15) steps to
    // RANK_MIN, so a corrupted rank self-heals on the next step.
    function automatic card_t next_rank(input card_t r);
        if (r >= RANK_MIN && r < RANK_MAX) begin
            return r + 4'd1;
        end
        return RANK_MIN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/card_shoe_rank_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rank_counter
//  Purpose  : Free-running rank counter 1..13 with 13 -> 1 wrap. Advances on
//             every clock edge; used as the card shoe's rank source.
//  Ports    : clk    - clock
//             rst_n  - asynchronous active-low reset (counter -> 1)
//             o_rank - current rank, always within 1..13
//  Revision : 1.0  initial release
// ============================================================================
module rank_counter
    import card_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] o_rank
);

    card_t r_rank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rank <= RANK_MIN;
        end else begin
            r_rank <= next_rank(r_rank);
        end
    end

    assign o_rank = r_rank;

endmodule
`default_nettype wire

// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
//  Module   : card_shoe
//  Purpose  : Finite-deck card source. Keeps per-rank counts for NUM_DECKS
//             decks and deals one card per draw, starting at the free-running
//             rank and probing upward (13 -> 1 wrap) past exhausted ranks.
//  Ports    : slow_clock - clock
//             resetb     - asynchronous active-low reset (shoe full, IDLE)
//             draw       - deal request, sampled only in IDLE
//             shuffle    - synchronous refill to full, wins over draw
//             new_card   - last dealt rank, held until the next deal
//             card_valid - one-cycle pulse when new_card updates
//             busy       - high while probing (SEARCH)
//             cards_left - cards remaining in the shoe
//             shoe_empty - high while in EMPTY
//  Revision : 1.0  initial release
// ============================================================================
module card_shoe
    import card_pkg::*;
#(
    parameter int NUM_DECKS = 1
)(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       draw,
    input  logic       shuffle,
    output logic [3:0] new_card,
    output logic       card_valid,
    output logic       busy,
    output logic [7:0] cards_left,
    output logic       shoe_empty
);

    localparam logic [4:0] C_FULL_RANK = 5'(4 * NUM_DECKS);
    localparam logic [7:0] C_FULL_SHOE = 8'(52 * NUM_DECKS);

    shoe_state_t r_state;
    shoe_state_t w_state_next;

    logic [4:0]  r_count [1:13];
    logic [7:0]  r_cards_left;
    card_t       r_probe;
    card_t       r_new_card;
    logic        r_card_valid;
    logic [3:0]  w_rng;
    logic        w_hit;
    logic        w_deal;
    logic        w_start;

    rank_counter u_rng (
        .clk    (slow_clock),
        .rst_n  (resetb),
        .o_rank (w_rng)
    );

    assign w_hit   = (r_count[r_probe] != 5'd0);
    assign w_start = !shuffle && (r_state == IDLE) && draw && (r_cards_left != 8'd0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_deal       = 1'b0;
        if (shuffle) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (draw) begin
                        w_state_next = (r_cards_left != 8'd0) ? SEARCH : EMPTY;
                    end
                end
                SEARCH: begin
                    if (w_hit) begin
                        w_deal       = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                EMPTY: begin
                    w_state_next = EMPTY;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 1; i <= 13; i++) begin
                r_count[i] <= C_FULL_RANK;
            end
            r_cards_left <= C_FULL_SHOE;
            r_probe      <= RANK_MIN;
            r_new_card   <= 4'd0;
            r_card_valid <= 1'b0;
        end else begin
            r_card_valid <= 1'b0;
            if (shuffle) begin
                for (int i = 1; i <= 13; i++) begin
                    r_count[i] <= C_FULL_RANK;
                end
                r_cards_left <= C_FULL_SHOE;
            end else if (w_start) begin
                r_probe <= w_rng;
            end else if (w_deal) begin
                r_new_card       <= r_probe;
                r_card_valid     <= 1'b1;
                r_count[r_probe] <= r_count[r_probe] - 5'd1;
                r_cards_left     <= r_cards_left - 8'd1;
            end else if (r_state == SEARCH) begin
                r_probe <= next_rank(r_probe);
            end
        end
    end

    assign new_card   = r_new_card;
    assign card_valid = r_card_valid;
    assign busy       = (r_state == SEARCH);
    assign shoe_empty = (r_state == EMPTY);
    assign cards_left = r_cards_left;

    // A deal only happens on a non-empty rank, so neither counter can wrap.
    a_no_underflow: assert property (@(posedge slow_clock) disable iff (!resetb)
        w_deal |-> (r_count[r_probe] != 5'd0 && r_cards_left != 8'd0));

    a_rng_range: assert property (@(posedge slow_clock) disable iff (!resetb)
        (w_rng >= RANK_MIN && w_rng <= RANK_MAX));

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_card_shoe
//  Purpose  : Self-checking bench for card_shoe (NUM_DECKS = 1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_card_shoe;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       draw       = 1'b0;
    logic       shuffle    = 1'b0;
    logic [3:0] new_card;
    logic       card_valid;
    logic       busy;
    logic [7:0] cards_left;
    logic       shoe_empty;

    int total = 0;
    int bad   = 0;

    // Independent model of the free-running rank source: 1..13, reset to 1.
    int m_rng = 1;

    card_shoe #(.NUM_DECKS(1)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .draw       (draw),
        .shuffle    (shuffle),
        .new_card   (new_card),
        .card_valid (card_valid),
        .busy       (busy),
        .cards_left (cards_left),
        .shoe_empty (shoe_empty)
    );

    always #5 slow_clock = ~slow_clock;

    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) m_rng <= 1;
        else         m_rng <= (m_rng == 13) ? 1 : m_rng + 1;
    end

    typedef struct {
        int rank;   // rng value on the sampling edge
        int card;   // expected dealt rank
        int lat;    // expected edges from sampling edge to card_valid
        int left;   // expected cards_left after the deal
    } vec_t;

    vec_t vt [11];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Draw sampled on an edge where rng == want (want == 0: next edge).
    // Returns the dealt card, latency in edges, and busy cycles observed.
    task automatic do_draw(input int want, output int card, output int lat,
                           output int bc);
        int guard;
        guard = 0;
        @(negedge slow_clock);
        while (want != 0 && m_rng != want && guard < 40) begin
            @(negedge slow_clock);
            guard++;
        end
        if (guard >= 40) check("rng_wait", guard, 0);
        draw = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        draw = 1'b0;
        bc   = busy ? 1 : 0;
        lat  = 0;
        card = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge slow_clock);
            lat++;
            @(negedge slow_clock);
            if (card_valid) begin
                card = int'(new_card);
                break;
            end
            if (busy) bc++;
        end
        if (card < 0) lat = 99;
    endtask

    task automatic do_shuffle();
        @(negedge slow_clock);
        shuffle = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        shuffle = 1'b0;
    endtask

    task automatic watch(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge slow_clock);
            if (card_valid) seen++;
        end
    endtask

    // Deal all four of ranks 1..12 from a full shoe; returns count of wrong deals.
    task automatic exhaust_low(output int errs);
        int c, l, b;
        errs = 0;
        for (int r = 1; r <= 12; r++) begin
            repeat (4) begin
                do_draw(r, c, l, b);
                if (c != r || l != 1) errs++;
            end
        end
    endtask

    // Start a draw at rng == 1 against an exhausted-low shoe and advance
    // two more edges, leaving the DUT mid-SEARCH at a negedge.
    task automatic start_long_search();
        int guard;
        guard = 0;
        @(negedge slow_clock);
        while (m_rng != 1 && guard < 40) begin
            @(negedge slow_clock);
            guard++;
        end
        draw = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        draw = 1'b0;
        check("search_busy", int'(busy), 1);
        repeat (2) @(negedge slow_clock);
    endtask

    initial begin
        int c, l, b, seen, errs;
        int tally [1:13];

        vt[0]  = '{5, 5, 1, 51};
        vt[1]  = '{7, 7, 1, 50};
        vt[2]  = '{7, 7, 1, 49};
        vt[3]  = '{7, 7, 1, 48};
        vt[4]  = '{7, 7, 1, 47};
        vt[5]  = '{7, 8, 2, 46};
        vt[6]  = '{13, 13, 1, 45};
        vt[7]  = '{13, 13, 1, 44};
        vt[8]  = '{13, 13, 1, 43};
        vt[9]  = '{13, 13, 1, 42};
        vt[10] = '{13, 1, 2, 41};

        repeat (3) @(negedge slow_clock);
        check("rst_new_card",   int'(new_card),   0);
        check("rst_card_valid", int'(card_valid), 0);
        check("rst_busy",       int'(busy),       0);
        check("rst_shoe_empty", int'(shoe_empty), 0);
        check("rst_cards_left", int'(cards_left), 52);
        resetb = 1'b1;

        // Table-driven deals from a fresh shoe.
        for (int i = 0; i < 11; i++) begin
            do_draw(vt[i].rank, c, l, b);
            check($sformatf("vec%0d_card", i), c, vt[i].card);
            check($sformatf("vec%0d_lat", i),  l, vt[i].lat);
            check($sformatf("vec%0d_busy", i), b, vt[i].lat);
            check($sformatf("vec%0d_left", i), int'(cards_left), vt[i].left);
            @(negedge slow_clock);
            check($sformatf("vec%0d_pulse", i), int'(card_valid), 0);
        end

        // Full shoe drain: each rank dealt exactly four times.
        do_shuffle();
        check("shuf_left", int'(cards_left), 52);
        for (int r = 1; r <= 13; r++) tally[r] = 0;
        for (int n = 0; n < 52; n++) begin
            do_draw(0, c, l, b);
            if (c >= 1 && c <= 13) tally[c]++;
        end
        check("drain_left",  int'(cards_left), 0);
        check("drain_empty", int'(shoe_empty), 0);
        for (int r = 1; r <= 13; r++) check($sformatf("tally_rank%0d", r), tally[r], 4);

        @(negedge slow_clock);
        draw = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        draw = 1'b0;
        check("empty_flag", int'(shoe_empty), 1);
        check("empty_busy", int'(busy), 0);
        check("empty_valid", int'(card_valid), 0);
        draw = 1'b1;
        watch(5, seen);
        draw = 1'b0;
        check("empty_no_deal", seen, 0);
        check("empty_stays", int'(shoe_empty), 1);
        do_shuffle();
        check("refill_left",  int'(cards_left), 52);
        check("refill_empty", int'(shoe_empty), 0);

        // Worst case: ranks 1..12 gone, probe walks 1..13.
        exhaust_low(errs);
        check("exhaust1_errs", errs, 0);
        check("exhaust1_left", int'(cards_left), 4);
        do_draw(1, c, l, b);
        check("worst_card", c, 13);
        check("worst_lat",  l, 13);
        check("worst_busy", b, 13);
        check("worst_left", int'(cards_left), 3);

        // Shuffle (with a simultaneous draw) during SEARCH.
        start_long_search();
        draw    = 1'b1;
        shuffle = 1'b1;
        @(posedge slow_clock);
        @(negedge slow_clock);
        draw    = 1'b0;
        shuffle = 1'b0;
        check("shufsrch_valid", int'(card_valid), 0);
        check("shufsrch_busy",  int'(busy), 0);
        check("shufsrch_left",  int'(cards_left), 52);
        check("shufsrch_card",  int'(new_card), 13);
        watch(15, seen);
        check("shufsrch_no_deal", seen, 0);
        do_draw(5, c, l, b);
        check("post_shuf_card", c, 5);
        check("post_shuf_lat",  l, 1);
        check("post_shuf_left", int'(cards_left), 51);

        // Async reset during SEARCH.
        do_shuffle();
        exhaust_low(errs);
        check("exhaust2_errs", errs, 0);
        start_long_search();
        resetb = 1'b0;
        @(posedge slow_clock);
        @(negedge slow_clock);
        check("rstsrch_valid", int'(card_valid), 0);
        check("rstsrch_busy",  int'(busy), 0);
        check("rstsrch_left",  int'(cards_left), 52);
        check("rstsrch_card",  int'(new_card), 0);
        resetb = 1'b1;
        watch(15, seen);
        check("rstsrch_no_deal", seen, 0);
        do_draw(5, c, l, b);
        check("post_rst_card", c, 5);
        check("post_rst_lat",  l, 1);
        check("post_rst_left", int'(cards_left), 51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
